// File: rtl/serial_sub10_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
// Contents: FSM state encoding, default operand width, counter width helper.
// No ports; imported by the interface, the datapath cell and the top.
package serial_sub_pkg;

  localparam int SUB_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // One extra bit beyond clog2 so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_sub10_if.sv
// serial_sub10_if: request/result bundle between a requester and serial_sub10.
// master: drives START, A, B; observes BUSY, DONE, DIFF, BOUT.
// slave : the subtractor side (directions reversed).
interface serial_sub10_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
);

  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] DIFF;
  logic             BOUT;

  modport master (
    output START, A, B,
    input  BUSY, DONE, DIFF, BOUT
  );

  modport slave (
    input  START, A, B,
    output BUSY, DONE, DIFF, BOUT
  );

endinterface

// File: rtl/serial_sub10_fs_bit.sv
// fs_bit: combinational 1-bit full subtractor, d = a - b - bin.
// Ports: a, b, bin (borrow in) -> d (difference bit), bout (borrow out).
// Purely combinational; no clock or reset.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they are equal and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub10.sv
// serial_sub10: bit-serial unsigned subtractor, DIFF = A - B mod 2^WIDTH, LSB first.
// Ports: CLK, RST (async active-high), bus (slave): START/A/B in, BUSY/DONE/DIFF/BOUT out.
// Timing: accept at edge k, BUSY cycles k+1..k+WIDTH, DONE pulse k+WIDTH+1; START ignored while BUSY.
module serial_sub10
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic           CLK,
  input  logic           RST,
  serial_sub10_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             bor;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             load;
  logic             step;
  logic             last;

  logic             d_bit;
  logic             bor_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Single shared cell; the borrow loops through the bor flop.
  fs_bit u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bor),
    .d    (d_bit),
    .bout (bor_nxt)
  );

  assign res_nxt = {d_bit, res_sr[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.START) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        // A request in the DONE cycle starts the next operation without an idle gap.
        if (bus.START) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      bor    <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (load) begin
      a_sr <= bus.A;
      b_sr <= bus.B;
      cnt  <= '0;
      bor  <= 1'b0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      bor    <= bor_nxt;
      cnt    <= cnt + CW'(1);
      // Outputs only change on entry to FIN, so partial results never show.
      if (last) begin
        diff_q <= res_nxt;
        bout_q <= bor_nxt;
      end
    end
  end

  assign bus.BUSY = (state == SHIFT);
  assign bus.DONE = (state == FIN);
  assign bus.DIFF = diff_q;
  assign bus.BOUT = bout_q;

endmodule

// File: tb/tb_serial_sub10.sv
module tb_serial_sub10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int errors = 0;
  int checks = 0;

  serial_sub10_if #(.WIDTH(10)) bus ();

  serial_sub10 #(.WIDTH(10)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // One operation from idle. Returns the cycle index (1 = first cycle after
  // the accept edge) at which DONE was seen, 0 on timeout.
  task automatic run_op(input logic [9:0] a, input logic [9:0] b,
                        output int done_at, output int busy_n,
                        output logic [9:0] d, output logic bo,
                        output logic after_done);
    done_at = 0;
    busy_n  = 0;
    d       = '0;
    bo      = 1'b0;
    @(negedge clk);
    bus.START = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.START = 1'b0;
    bus.A     = 10'($urandom);
    bus.B     = 10'($urandom);
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.DONE) begin
        done_at = i;
        d       = bus.DIFF;
        bo      = bus.BOUT;
        break;
      end
      if (bus.BUSY) busy_n++;
    end
    @(negedge clk);
    after_done = bus.DONE;
  endtask

  task automatic test_reset();
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.DONE); end
    checks++; if (bus.DIFF !== 10'd0) begin errors++; $display("FAIL reset_diff: got %0d expected 0", bus.DIFF); end
    checks++; if (bus.BOUT !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b expected 0", bus.BOUT); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int done_at, busy_n;
    logic [9:0] d;
    logic bo, after;
    run_op(10'd5, 10'd3, done_at, busy_n, d, bo, after);
    checks++; if (done_at !== 11) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 11", done_at); end
    checks++; if (busy_n !== 10) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 10", busy_n); end
    checks++; if (d !== 10'd2) begin errors++; $display("FAIL basic_diff: got %0d expected 2", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_bout: got %b expected 0", bo); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL basic_done_pulse_width: got %b expected 0", after); end
  endtask

  task automatic test_vectors();
    logic [9:0] va [4] = '{10'd3, 10'd0, 10'd1023, 10'd512};
    logic [9:0] vb [4] = '{10'd5, 10'd1, 10'd0,    10'd512};
    logic [9:0] vd [4] = '{10'd1022, 10'd1023, 10'd1023, 10'd0};
    logic       vo [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int done_at, busy_n;
    logic [9:0] d;
    logic bo, after;
    for (int k = 0; k < 4; k++) begin
      run_op(va[k], vb[k], done_at, busy_n, d, bo, after);
      checks++; if (done_at !== 11) begin errors++; $display("FAIL vec%0d_done_cycle: got %0d expected 11", k, done_at); end
      checks++; if (d !== vd[k]) begin errors++; $display("FAIL vec%0d_diff: got %0d expected %0d", k, d, vd[k]); end
      checks++; if (bo !== vo[k]) begin errors++; $display("FAIL vec%0d_bout: got %b expected %b", k, bo, vo[k]); end
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int first = 0;
    logic [9:0] d = '0;
    @(negedge clk);
    bus.START = 1'b1;
    bus.A     = 10'd7;
    bus.B     = 10'd2;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.DONE) begin
        dones++;
        if (first == 0) begin first = i; d = bus.DIFF; end
      end
      if (i == 4) begin
        bus.START = 1'b1;
        bus.A     = 10'd100;
        bus.B     = 10'd1;
      end else begin
        bus.START = 1'b0;
      end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
    checks++; if (first !== 11) begin errors++; $display("FAIL ignore_done_cycle: got %0d expected 11", first); end
    checks++; if (d !== 10'd5) begin errors++; $display("FAIL ignore_diff: got %0d expected 5", d); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int t1 = 0, t2 = 0;
    logic [9:0] d1 = '0, d2 = '0;
    @(negedge clk);
    bus.START = 1'b1;
    bus.A     = 10'd10;
    bus.B     = 10'd4;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.DONE) begin
        dones++;
        if (dones == 1) begin
          t1 = i; d1 = bus.DIFF;
          bus.A = 10'd9;
          bus.B = 10'd9;
        end else if (dones == 2) begin
          t2 = i; d2 = bus.DIFF;
          bus.START = 1'b0;
        end
      end
    end
    bus.START = 1'b0;
    checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
    checks++; if (t1 !== 11) begin errors++; $display("FAIL b2b_first_done: got %0d expected 11", t1); end
    checks++; if (t2 - t1 !== 11) begin errors++; $display("FAIL b2b_gap: got %0d expected 11", t2 - t1); end
    checks++; if (d1 !== 10'd6) begin errors++; $display("FAIL b2b_diff1: got %0d expected 6", d1); end
    checks++; if (d2 !== 10'd0) begin errors++; $display("FAIL b2b_diff2: got %0d expected 0", d2); end
  endtask

  task automatic test_reset_abort();
    int done_at, busy_n;
    int dones = 0;
    logic [9:0] d;
    logic bo, after;
    run_op(10'd50, 10'd20, done_at, busy_n, d, bo, after);
    checks++; if (bus.DIFF !== 10'd30) begin errors++; $display("FAIL abort_pre_diff: got %0d expected 30", bus.DIFF); end
    @(negedge clk);
    bus.START = 1'b1;
    bus.A     = 10'd900;
    bus.B     = 10'd37;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      bus.START = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.BUSY); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus.DONE); end
    checks++; if (bus.DIFF !== 10'd0) begin errors++; $display("FAIL abort_diff: got %0d expected 0", bus.DIFF); end
    checks++; if (bus.BOUT !== 1'b0) begin errors++; $display("FAIL abort_bout: got %b expected 0", bus.BOUT); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.DONE) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    run_op(10'd900, 10'd37, done_at, busy_n, d, bo, after);
    checks++; if (done_at !== 11) begin errors++; $display("FAIL abort_rerun_done: got %0d expected 11", done_at); end
    checks++; if (d !== 10'd863) begin errors++; $display("FAIL abort_rerun_diff: got %0d expected 863", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL abort_rerun_bout: got %b expected 0", bo); end
  endtask

  // Back-to-back random operands; A/B are scrambled while BUSY to show the
  // operands in flight are held internally.
  task automatic test_random();
    localparam int N = 3000;
    int issued = 0;
    int dones  = 0;
    int idle_n = 0;
    int extra  = 0;
    logic [9:0] ea, eb, ed;
    logic       eo;
    @(negedge clk);
    ea = 10'($urandom);
    eb = 10'($urandom);
    bus.START = 1'b1;
    bus.A     = ea;
    bus.B     = eb;
    issued    = 1;
    while (dones < N) begin
      @(negedge clk);
      if (bus.DONE) begin
        dones++;
        ed = ea - eb;
        eo = (ea < eb);
        checks++; if (bus.DIFF !== ed) begin errors++; $display("FAIL rand_diff: A=%0d B=%0d got %0d expected %0d", ea, eb, bus.DIFF, ed); end
        checks++; if (bus.BOUT !== eo) begin errors++; $display("FAIL rand_bout: A=%0d B=%0d got %b expected %b", ea, eb, bus.BOUT, eo); end
        idle_n = 0;
        if (dones < N) begin
          ea = 10'($urandom);
          eb = 10'($urandom);
          bus.A = ea;
          bus.B = eb;
          issued++;
        end else begin
          bus.START = 1'b0;
        end
      end else begin
        bus.A = 10'($urandom);
        bus.B = 10'($urandom);
        idle_n++;
        if (idle_n > 15) begin
          errors++; checks++;
          $display("FAIL rand_timeout: got no DONE in 15 cycles expected DONE after op %0d", dones);
          break;
        end
      end
    end
    bus.START = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.DONE) extra++;
    end
    checks++; if (dones !== issued) begin errors++; $display("FAIL rand_done_count: got %0d expected %0d", dones, issued); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL rand_extra_done: got %0d expected 0", extra); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
